// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported instruction/data memory between
// the fetch stage (instruction port) and the memory stage (data port).
// Each access runs as a req/ack handshake. The data port has fixed priority.
// A one-cycle ready pulse returns the result to the winning port, and freeze
// stays asserted while either port is waiting.
// Optional build macro: ARB_PERF_CNT_EN adds the stall_cnt and conflict_cnt
// performance counters.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_rd_en,
    input  logic              d_wr_en,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              freeze,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic              d_req_s;
    logic              mem_req_r, mem_req_s;
    logic              mem_we_r, mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic [DATA_W-1:0] if_rdata_r, if_rdata_s;
    logic [DATA_W-1:0] d_rdata_r, d_rdata_s;
    logic              if_ready_r, if_ready_s;
    logic              d_ready_r, d_ready_s;

    // A write and a read asserted together is illegal and is treated as a write.
    assign d_req_s = d_rd_en | d_wr_en;

    // State register; reset abandons any in-flight access, so a late ack finds IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: data wins in IDLE; RESP always returns to IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (d_req_s) begin
                    state_s = BUSY_D;
                end else if (if_req) begin
                    state_s = BUSY_I;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY_D, BUSY_I: begin
                if (mem_ack) begin
                    state_s = RESP;
                end else begin
                    state_s = state_r;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output logic: computes the next value of each registered output.
    always_comb begin
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        if_rdata_s  = if_rdata_r;
        d_rdata_s   = d_rdata_r;
        if_ready_s  = 1'b0;
        d_ready_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (d_req_s) begin
                    mem_req_s   = 1'b1;
                    mem_we_s    = d_wr_en;
                    mem_addr_s  = d_addr;
                    mem_wdata_s = d_wdata;
                end else if (if_req) begin
                    mem_req_s  = 1'b1;
                    mem_we_s   = 1'b0;
                    mem_addr_s = if_addr;
                end else begin
                    mem_req_s = 1'b0;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    mem_req_s = 1'b0;
                    d_ready_s = 1'b1;
                    if (!mem_we_r) begin
                        d_rdata_s = mem_rdata;
                    end else begin
                        d_rdata_s = d_rdata_r;
                    end
                end else begin
                    mem_req_s = 1'b1;
                end
            end
            BUSY_I: begin
                if (mem_ack) begin
                    mem_req_s  = 1'b0;
                    if_ready_s = 1'b1;
                    if_rdata_s = mem_rdata;
                end else begin
                    mem_req_s = 1'b1;
                end
            end
            RESP:    mem_req_s = 1'b0;
            default: mem_req_s = 1'b0;
        endcase
    end

    // Output registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            if_rdata_r  <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
            if_ready_r  <= 1'b0;
            d_ready_r   <= 1'b0;
        end else begin
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            if_rdata_r  <= if_rdata_s;
            d_rdata_r   <= d_rdata_s;
            if_ready_r  <= if_ready_s;
            d_ready_r   <= d_ready_s;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_rdata  = if_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign if_ready  = if_ready_r;
    assign d_ready   = d_ready_r;

    // Freeze is combinational so the pipeline stalls in the same cycle a request appears.
    assign freeze = ~rst & ((if_req & ~if_ready_r) | (d_req_s & ~d_ready_r));

`ifdef ARB_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] conflict_cnt_r;

    // Performance counters: stall cycles and IDLE cycles with both ports requesting.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r    <= 32'd0;
            conflict_cnt_r <= 32'd0;
        end else begin
            if (freeze) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if ((state_r == IDLE) && d_req_s && if_req) begin
                conflict_cnt_r <= conflict_cnt_r + 32'd1;
            end else begin
                conflict_cnt_r <= conflict_cnt_r;
            end
        end
    end

    assign stall_cnt    = stall_cnt_r;
    assign conflict_cnt = conflict_cnt_r;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change 1 time unit after
// each rising edge. Outputs are checked 1 time unit after the next rising edge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_rd_en;
    logic        d_wr_en;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        freeze;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] conflict_cnt;
    logic [31:0] stall_base;
`endif

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_rd_en   (d_rd_en),
        .d_wr_en   (d_wr_en),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .freeze    (freeze),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef ARB_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Directed stimulus sequence.
    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; d_rd_en = 1'b0; d_wr_en = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;

        // Reset for 2 cycles, plus an ack pulse during reset.
        step(); step();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_freeze", {31'd0, freeze}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
        step();
        check("rst_ack_if_ready", {31'd0, if_ready}, 32'd0);
        check("rst_ack_d_ready", {31'd0, d_ready}, 32'd0);
        // An ack while IDLE is ignored.
        rst = 1'b0;
        step();
        check("idle_ack_if_ready", {31'd0, if_ready}, 32'd0);
        check("idle_ack_d_ready", {31'd0, d_ready}, 32'd0);
        check("idle_ack_mem_req", {31'd0, mem_req}, 32'd0);
        check("idle_ack_if_rdata", if_rdata, 32'd0);
        mem_ack = 1'b0;

        // Instruction fetch at 0x100; the memory acks in the second mem_req cycle.
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        check("if_freeze_early", {31'd0, freeze}, 32'd1);
        step();
        check("if_mem_req_c1", {31'd0, mem_req}, 32'd1);
        check("if_mem_addr", mem_addr, 32'h100);
        check("if_mem_we", {31'd0, mem_we}, 32'd0);
        check("if_freeze_c1", {31'd0, freeze}, 32'd1);
        step();
        check("if_mem_req_c2", {31'd0, mem_req}, 32'd1);
        check("if_ready_c2", {31'd0, if_ready}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hE3A01005;
        step();
        mem_ack = 1'b0;
        check("if_mem_req_off", {31'd0, mem_req}, 32'd0);
        check("if_ready_pulse", {31'd0, if_ready}, 32'd1);
        check("if_rdata", if_rdata, 32'hE3A01005);
        check("if_freeze_done", {31'd0, freeze}, 32'd0);
        if_req = 1'b0;
        step();
        check("if_ready_end", {31'd0, if_ready}, 32'd0);
        check("if_rdata_hold", if_rdata, 32'hE3A01005);

        // Data write to 0x40; ack data on the bus must not reach d_rdata.
        d_wr_en = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        step();
        check("wr_mem_req", {31'd0, mem_req}, 32'd1);
        check("wr_mem_we", {31'd0, mem_we}, 32'd1);
        check("wr_mem_addr", mem_addr, 32'h40);
        check("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        step();
        mem_ack = 1'b0;
        check("wr_d_ready", {31'd0, d_ready}, 32'd1);
        check("wr_d_rdata_kept", d_rdata, 32'd0);
        check("wr_if_ready", {31'd0, if_ready}, 32'd0);
        d_wr_en = 1'b0;
        step();
        check("wr_d_ready_end", {31'd0, d_ready}, 32'd0);

        // Read back from 0x40.
        d_rd_en = 1'b1; d_addr = 32'h40;
        step();
        check("rd_mem_we", {31'd0, mem_we}, 32'd0);
        check("rd_mem_addr", mem_addr, 32'h40);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        mem_ack = 1'b0;
        check("rd_d_ready", {31'd0, d_ready}, 32'd1);
        check("rd_d_rdata", d_rdata, 32'hDEADBEEF);
        d_rd_en = 1'b0;
        step();
        check("rd_d_ready_end", {31'd0, d_ready}, 32'd0);
        check("rd_d_rdata_hold", d_rdata, 32'hDEADBEEF);

        // Read and write together count as a write; the request is dropped before
        // ack but still completes.
        d_rd_en = 1'b1; d_wr_en = 1'b1; d_addr = 32'h44; d_wdata = 32'h5;
        step();
        check("rw_mem_we", {31'd0, mem_we}, 32'd1);
        check("rw_mem_wdata", mem_wdata, 32'h5);
        d_rd_en = 1'b0; d_wr_en = 1'b0;
        step();
        check("drop_mem_req", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD0BAD;
        step();
        mem_ack = 1'b0;
        check("drop_d_ready", {31'd0, d_ready}, 32'd1);
        check("drop_d_rdata_kept", d_rdata, 32'hDEADBEEF);
        step();

        // Instruction and data requests rise together; data is served first.
`ifdef ARB_PERF_CNT_EN
        stall_base = stall_cnt;
`endif
        if_req = 1'b1; if_addr = 32'h8; d_rd_en = 1'b1; d_addr = 32'h20;
        step();
        check("sim_mem_addr_d", mem_addr, 32'h20);
        check("sim_freeze_1", {31'd0, freeze}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hAAAA5555;
        step();
        mem_ack = 1'b0;
        check("sim_d_ready", {31'd0, d_ready}, 32'd1);
        check("sim_d_rdata", d_rdata, 32'hAAAA5555);
        check("sim_if_ready_0", {31'd0, if_ready}, 32'd0);
        check("sim_freeze_2", {31'd0, freeze}, 32'd1);
        d_rd_en = 1'b0;
        step();
        check("sim_mem_req_idle", {31'd0, mem_req}, 32'd0);
        check("sim_freeze_3", {31'd0, freeze}, 32'd1);
        step();
        check("sim_mem_req_i", {31'd0, mem_req}, 32'd1);
        check("sim_mem_addr_i", mem_addr, 32'h8);
        check("sim_freeze_4", {31'd0, freeze}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h11112222;
        step();
        mem_ack = 1'b0;
        check("sim_if_ready", {31'd0, if_ready}, 32'd1);
        check("sim_if_rdata", if_rdata, 32'h11112222);
        check("sim_freeze_off", {31'd0, freeze}, 32'd0);
        if_req = 1'b0;
        step();
`ifdef ARB_PERF_CNT_EN
        check("perf_conflict", conflict_cnt, 32'd1);
        check("perf_stall_delta", stall_cnt - stall_base, 32'd5);
`endif

        // Reset while a data read is busy; a late ack is then ignored.
        d_rd_en = 1'b1; d_addr = 32'h30;
        step();
        check("abort_mem_req_on", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        step();
        check("abort_mem_req_off", {31'd0, mem_req}, 32'd0);
        check("abort_d_ready", {31'd0, d_ready}, 32'd0);
        check("abort_freeze_rst", {31'd0, freeze}, 32'd0);
        check("abort_d_rdata_clr", d_rdata, 32'd0);
        rst = 1'b0; d_rd_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77777777;
        step();
        mem_ack = 1'b0;
        check("late_ack_d_ready", {31'd0, d_ready}, 32'd0);
        check("late_ack_if_ready", {31'd0, if_ready}, 32'd0);
        check("late_ack_d_rdata", d_rdata, 32'd0);
        if_req = 1'b1; if_addr = 32'h200;
        step();
        check("post_mem_addr", mem_addr, 32'h200);
        check("post_mem_req", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        step();
        mem_ack = 1'b0;
        check("post_if_ready", {31'd0, if_ready}, 32'd1);
        check("post_if_rdata", if_rdata, 32'hCAFEF00D);
        if_req = 1'b0;
        step();
        check("post_if_ready_end", {31'd0, if_ready}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-ported instruction/data memory between the fetch stage (instruction port) and the memory stage (data port).
- Sequences each access through a req/ack handshake to the memory.
- Returns read data and a one-cycle ready pulse to the winning port.
- Drives a pipeline freeze while any port is waiting. Sits between IfStage/MemStage and the external memory; freeze feeds the hazard/freeze logic.

Parameters:
- ADDR_W, 32, address width of both ports and memory.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  instruction read request (level, held until if_ready)
- if_addr  in  ADDR_W  instruction address
- if_rdata  out  DATA_W  instruction read data, valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse, instruction port
- d_rd_en  in  1  data read request (level)
- d_wr_en  in  1  data write request (level)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  data write data
- d_rdata  out  DATA_W  data read data, valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse, data port
- freeze  out  1  pipeline freeze request
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1=write, 0=read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory

Behaviour:
- States: IDLE, BUSY_D, BUSY_I, RESP.
- Reset (synchronous, rst=1 at edge):
  - State goes to IDLE.
  - mem_req, mem_we, if_ready and d_ready go to 0.
  - mem_addr, mem_wdata, if_rdata and d_rdata go to 0.
  - An in-flight access is abandoned; a later mem_ack is ignored.
- IDLE:
  - If d_rd_en or d_wr_en is high: latch d_addr, d_wdata and we=d_wr_en into mem_* registers; next cycle mem_req=1; go to BUSY_D.
  - Else if if_req is high: latch if_addr with we=0; mem_req=1; go to BUSY_I.
  - Data port has fixed priority, since it serves the older instruction.
  - d_rd_en and d_wr_en both high is illegal and is treated as a write.
- BUSY_x:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - On mem_ack: mem_req goes to 0.
  - For a read, mem_rdata is captured into if_rdata or d_rdata for the owning port.
  - The owning port's ready goes to 1 for the next cycle; go to RESP.
  - A write leaves d_rdata unchanged.
- RESP:
  - Exactly one ready is high for this single cycle.
  - No new request is sampled, so the requester can drop or change its request.
  - Next state is IDLE.
- rdata registers hold their value until the next read completes on the same port.
- Latency: request sampled in IDLE at edge N, mem_req high from N+1, mem_ack at cycle N+k (k>=1), ready high in cycle N+k+1. Minimum 3 cycles per access; one access in flight at a time.
- freeze is combinational: (if_req & ~if_ready) | ((d_rd_en|d_wr_en) & ~d_ready). It is 0 during rst.
- A request dropped before ready is not cancelled: the access completes and ready still pulses.
- A mem_ack arriving outside BUSY_x is ignored.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[31:0] and conflict_cnt[31:0], both 0 on reset.
  - stall_cnt increments every cycle freeze=1.
  - conflict_cnt increments on each IDLE cycle where a data request and if_req are both high.
  - Both counters wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset with rst=1 for 2 cycles, no requests -> all outputs 0, state IDLE; mem_ack pulse ignored.
- if_req=1, if_addr=0x100, memory acks 2 cycles after mem_req with 0xE3A01005:
  - mem_req high exactly 2 cycles with mem_addr=0x100, mem_we=0.
  - if_ready pulses 1 cycle with if_rdata=0xE3A01005; freeze=1 until that cycle.
- d_wr_en=1, d_addr=0x40, d_wdata=0xDEADBEEF:
  - mem_we=1, mem_wdata=0xDEADBEEF, d_ready pulses once.
  - A subsequent d_rd_en at 0x40 returns d_rdata=0xDEADBEEF.
- if_req and d_rd_en rise in the same cycle (if_addr=0x8, d_addr=0x20):
  - Data is served first (mem_addr=0x20), then instruction (mem_addr=0x8) after RESP/IDLE.
  - freeze stays 1 until the final if_ready.
- rst asserted while in BUSY_D before mem_ack:
  - mem_req drops at the next edge, no ready pulse.
  - A late mem_ack is ignored; the next if_req is served normally.
- With ARB_PERF_CNT_EN, rerun the simultaneous-request case -> conflict_cnt=1, stall_cnt equals the number of freeze=1 cycles.
